// File: rtl/cnn_pkg.sv
// Shared constants and types for the pixel-stream front end of the CNN datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

    // Default pixel width and frame geometry (28x28, 8-bit greyscale).
    localparam int DEFAULT_WI    = 8;
    localparam int DEFAULT_IMG_W = 28;
    localparam int DEFAULT_IMG_H = 28;

    // Window generator control state.
    //   FILL : first two lines of a frame are loading the line buffers.
    //   RUN  : line buffers hold the two previous lines, windows may be emitted.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// Enable-gated line delay: oData is iData delayed by DEPTH accepted samples.
// Latency: DEPTH enabled cycles; the tap is a register output, readable before the shift.
// Backpressure: none; iEn low freezes the whole delay line.
//
// Ports:
//   iClk  - clock
//   iRsn  - asynchronous active-low reset (clears contents)
//   iEn   - shift enable, one sample per enabled cycle
//   iData - sample entering the line
//   oData - sample that entered DEPTH enabled cycles ago
module line_buffer
    import cnn_pkg::*;
#(
    parameter int WI    = DEFAULT_WI,
    parameter int DEPTH = DEFAULT_IMG_W
) (
    input  logic          iClk,
    input  logic          iRsn,
    input  logic          iEn,
    input  logic [WI-1:0] iData,
    output logic [WI-1:0] oData
);

    // Register chain; element 0 is the newest sample, DEPTH-1 the oldest.
    logic [DEPTH-1:0][WI-1:0] sr_q;
    logic [DEPTH-1:0][WI-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (iEn) begin
            sr_d[0] = iData;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign oData = sr_q[DEPTH-1];

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: raster pixel stream in, fully-inside 3x3 windows out.
// Latency: 1 cycle from the accepting edge of a window's bottom-right pixel to oOutValid.
// Backpressure: none; iInValid low freezes all state and the window bus holds its value.
//
// Ports:
//   iClk, iRsn      - clock, asynchronous active-low reset
//   iInValid/iInData - one raster-order pixel per valid cycle
//   oOutValid        - one-cycle strobe per emitted window (registered)
//   oWindowOutRow1-3 - top/middle/bottom window rows, {left, centre, right}, left in the MSBs
//   oFrameDone       - pulses with the window of the frame's bottom-right pixel
module window3x3_gen
    import cnn_pkg::*;
#(
    parameter int WI    = DEFAULT_WI,
    parameter int IMG_W = DEFAULT_IMG_W,
    parameter int IMG_H = DEFAULT_IMG_H
) (
    input  logic          iClk,
    input  logic          iRsn,
    input  logic          iInValid,
    input  logic [WI-1:0] iInData,
    output logic          oOutValid,
    output logic [3*WI-1:0] oWindowOutRow1,
    output logic [3*WI-1:0] oWindowOutRow2,
    output logic [3*WI-1:0] oWindowOutRow3,
    output logic          oFrameDone
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    win_state_e    state_q, state_d;

    // Window registers indexed [row][col]; row 0 = top, col 0 = left.
    logic [2:0][2:0][WI-1:0] win_q, win_d;

    logic out_vld_q, out_vld_d;
    logic done_q, done_d;

    logic [WI-1:0] lb0_tap;   // pixel (row-1, col)
    logic [WI-1:0] lb1_tap;   // pixel (row-2, col)

    logic col_last;
    logic row_last;
    logic win_ok;

    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // ------------------------------------------------------------------
    // Line buffers: LB0 delays the input by one line, LB1 by two.
    // ------------------------------------------------------------------
    line_buffer #(
        .WI    (WI),
        .DEPTH (IMG_W)
    ) u_lb0 (
        .iClk  (iClk),
        .iRsn  (iRsn),
        .iEn   (iInValid),
        .iData (iInData),
        .oData (lb0_tap)
    );

    line_buffer #(
        .WI    (WI),
        .DEPTH (IMG_W)
    ) u_lb1 (
        .iClk  (iClk),
        .iRsn  (iRsn),
        .iEn   (iInValid),
        .iData (lb0_tap),
        .oData (lb1_tap)
    );

    // ------------------------------------------------------------------
    // FSM: FILL gates off windows while the line buffers still hold
    // the previous frame's lines, so stale data can never be emitted.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        win_ok  = 1'b0;
        case (state_q)
            FILL: begin
                if (iInValid && (row_q == RW'(1)) && col_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Columns 0 and 1 would straddle the previous line.
                win_ok = iInValid && (col_q >= CW'(2));
                if (iInValid && row_last && col_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Counters, window shift and output strobes.
    // ------------------------------------------------------------------
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        out_vld_d = win_ok;
        done_d    = win_ok && row_last && col_last;

        if (iInValid) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end

            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_tap;
            win_d[1][2] = lb0_tap;
            win_d[2][2] = iInData;
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            out_vld_q <= out_vld_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------
    assign oOutValid      = out_vld_q;
    assign oFrameDone     = done_q;
    assign oWindowOutRow1 = {win_q[0][0], win_q[0][1], win_q[0][2]};
    assign oWindowOutRow2 = {win_q[1][0], win_q[1][1], win_q[1][2]};
    assign oWindowOutRow3 = {win_q[2][0], win_q[2][1], win_q[2][2]};

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: a 4x4 instance for the directed frame scenarios and
// a default 28x28 instance for a random frame, both checked against an image
// array reference that builds each window from the frame's pixel coordinates.
module tb_window3x3_gen;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int BW = 28;
    localparam int BH = 28;

    logic clk = 1'b0;
    logic rst_n;

    logic        vld_s, ovld_s, done_s;
    logic [7:0]  dat_s;
    logic [23:0] r1_s, r2_s, r3_s;

    logic        vld_b, ovld_b, done_b;
    logic [7:0]  dat_b;
    logic [23:0] r1_b, r2_b, r3_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] img_s [SH][SW];
    logic [7:0] img_b [BH][BW];

    always #5 clk = ~clk;

    window3x3_gen #(.WI(8), .IMG_W(SW), .IMG_H(SH)) u_small (
        .iClk(clk), .iRsn(rst_n), .iInValid(vld_s), .iInData(dat_s),
        .oOutValid(ovld_s), .oWindowOutRow1(r1_s), .oWindowOutRow2(r2_s),
        .oWindowOutRow3(r3_s), .oFrameDone(done_s)
    );

    window3x3_gen #(.WI(8), .IMG_W(BW), .IMG_H(BH)) u_big (
        .iClk(clk), .iRsn(rst_n), .iInValid(vld_b), .iInData(dat_b),
        .oOutValid(ovld_b), .oWindowOutRow1(r1_b), .oWindowOutRow2(r2_b),
        .oWindowOutRow3(r3_b), .oFrameDone(done_b)
    );

    // Reference window rows: three horizontally adjacent pixels ending at column c.
    function automatic logic [23:0] srow(input int rr, input int c);
        return {img_s[rr][c-2], img_s[rr][c-1], img_s[rr][c]};
    endfunction

    function automatic logic [23:0] brow(input int rr, input int c);
        return {img_b[rr][c-2], img_b[rr][c-1], img_b[rr][c]};
    endfunction

    // Drive one cycle; outputs are then read 1 time unit after the edge.
    task automatic step_s(input logic v, input logic [7:0] d);
        vld_s = v;
        dat_s = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [7:0] d);
        vld_b = v;
        dat_b = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld_s = 1'b0; dat_s = '0;
        vld_b = 1'b0; dat_b = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ovld_s, done_s} !== 2'b00) begin
            fails++; $display("FAIL reset_small_strobes got %b exp 00", {ovld_s, done_s});
        end
        tests++;
        if ({r1_s, r2_s, r3_s} !== 72'h0) begin
            fails++; $display("FAIL reset_small_rows got %h exp 0", {r1_s, r2_s, r3_s});
        end
        tests++;
        if ({ovld_b, done_b} !== 2'b00) begin
            fails++; $display("FAIL reset_big_strobes got %b exp 00", {ovld_b, done_b});
        end
        tests++;
        if ({r1_b, r2_b, r3_b} !== 72'h0) begin
            fails++; $display("FAIL reset_big_rows got %h exp 0", {r1_b, r2_b, r3_b});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame_4x4();
        int nwin = 0;
        int r, c;
        logic ev, ed;
        for (int k = 0; k < SW * SH; k++) begin
            r = k / SW; c = k % SW;
            img_s[r][c] = 8'(k);
            step_s(1'b1, 8'(k));
            ev = (r >= 2) && (c >= 2);
            ed = (r == SH - 1) && (c == SW - 1);
            tests++;
            if (ovld_s !== ev) begin
                fails++; $display("FAIL frame_vld k=%0d got %b exp %b", k, ovld_s, ev);
            end
            tests++;
            if (done_s !== ed) begin
                fails++; $display("FAIL frame_done k=%0d got %b exp %b", k, done_s, ed);
            end
            if (ev) begin
                tests++;
                if ({r1_s, r2_s, r3_s} !== {srow(r-2, c), srow(r-1, c), srow(r, c)}) begin
                    fails++; $display("FAIL frame_win k=%0d got %h exp %h", k,
                        {r1_s, r2_s, r3_s}, {srow(r-2, c), srow(r-1, c), srow(r, c)});
                end
                if (nwin == 0) begin
                    tests++;
                    if ({r1_s, r2_s, r3_s} !== 72'h000102_040506_08090A) begin
                        fails++; $display("FAIL frame_first got %h exp 00010204050608090a", {r1_s, r2_s, r3_s});
                    end
                end
                if (ed) begin
                    tests++;
                    if ({r1_s, r2_s, r3_s} !== 72'h050607_090A0B_0D0E0F) begin
                        fails++; $display("FAIL frame_last got %h exp 050607090a0b0d0e0f", {r1_s, r2_s, r3_s});
                    end
                end
                nwin++;
            end
        end
        tests++;
        if (nwin != 4) begin
            fails++; $display("FAIL frame_count got %0d exp 4", nwin);
        end
    endtask

    task automatic test_gaps();
        int nwin = 0;
        int r, c;
        logic ev, ed;
        logic [71:0] ew;
        for (int k = 0; k < SW * SH; k++) begin
            r = k / SW; c = k % SW;
            img_s[r][c] = 8'(k);
            step_s(1'b1, 8'(k));
            ev = (r >= 2) && (c >= 2);
            ed = (r == SH - 1) && (c == SW - 1);
            ew = ev ? {srow(r-2, c), srow(r-1, c), srow(r, c)} : 72'h0;
            tests++;
            if ({ovld_s, done_s} !== {ev, ed}) begin
                fails++; $display("FAIL gaps_strobes k=%0d got %b exp %b", k, {ovld_s, done_s}, {ev, ed});
            end
            if (ev) begin
                nwin++;
                tests++;
                if ({r1_s, r2_s, r3_s} !== ew) begin
                    fails++; $display("FAIL gaps_win k=%0d got %h exp %h", k, {r1_s, r2_s, r3_s}, ew);
                end
            end
            step_s(1'b0, 8'hEE);
            tests++;
            if ({ovld_s, done_s} !== 2'b00) begin
                fails++; $display("FAIL gaps_idle_strobes k=%0d got %b exp 00", k, {ovld_s, done_s});
            end
            if (ev) begin
                tests++;
                if ({r1_s, r2_s, r3_s} !== ew) begin
                    fails++; $display("FAIL gaps_hold k=%0d got %h exp %h", k, {r1_s, r2_s, r3_s}, ew);
                end
            end
        end
        tests++;
        if (nwin != 4) begin
            fails++; $display("FAIL gaps_count got %0d exp 4", nwin);
        end
    endtask

    task automatic test_back_to_back();
        int nwin = 0, ndone = 0;
        int fk, r, c;
        logic ev, ed;
        for (int k = 0; k < 2 * SW * SH; k++) begin
            fk = k % (SW * SH);
            r = fk / SW; c = fk % SW;
            img_s[r][c] = 8'(k);
            step_s(1'b1, 8'(k));
            ev = (r >= 2) && (c >= 2);
            ed = (r == SH - 1) && (c == SW - 1);
            tests++;
            if ({ovld_s, done_s} !== {ev, ed}) begin
                fails++; $display("FAIL b2b_strobes k=%0d got %b exp %b", k, {ovld_s, done_s}, {ev, ed});
            end
            if (ovld_s) nwin++;
            if (done_s) ndone++;
            if (ev) begin
                tests++;
                if ({r1_s, r2_s, r3_s} !== {srow(r-2, c), srow(r-1, c), srow(r, c)}) begin
                    fails++; $display("FAIL b2b_win k=%0d got %h exp %h", k,
                        {r1_s, r2_s, r3_s}, {srow(r-2, c), srow(r-1, c), srow(r, c)});
                end
            end
            if (k == SW * SH + 10) begin
                tests++;
                if ({r1_s, r2_s, r3_s} !== 72'h101112_141516_18191A) begin
                    fails++; $display("FAIL b2b_frame2_first got %h exp 10111214151618191a", {r1_s, r2_s, r3_s});
                end
            end
        end
        tests++;
        if (nwin != 8 || ndone != 2) begin
            fails++; $display("FAIL b2b_counts got win=%0d done=%0d exp win=8 done=2", nwin, ndone);
        end
    endtask

    task automatic test_reset_midframe();
        int nwin = 0, ndone = 0;
        int r, c;
        logic ev, ed;
        for (int k = 0; k < 9; k++) begin
            step_s(1'b1, 8'(8'h40 + k));
        end
        rst_n = 1'b0;
        vld_s = 1'b1;
        dat_s = 8'hAA;
        #1;
        tests++;
        if ({ovld_s, done_s, r1_s, r2_s, r3_s} !== 74'h0) begin
            fails++; $display("FAIL midrst_async got %h exp 0", {ovld_s, done_s, r1_s, r2_s, r3_s});
        end
        @(posedge clk);
        #1;
        tests++;
        if ({ovld_s, done_s, r1_s, r2_s, r3_s} !== 74'h0) begin
            fails++; $display("FAIL midrst_held got %h exp 0", {ovld_s, done_s, r1_s, r2_s, r3_s});
        end
        rst_n = 1'b1;
        vld_s = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < SW * SH; k++) begin
            r = k / SW; c = k % SW;
            img_s[r][c] = 8'(8'h60 + k);
            step_s(1'b1, 8'(8'h60 + k));
            ev = (r >= 2) && (c >= 2);
            ed = (r == SH - 1) && (c == SW - 1);
            tests++;
            if ({ovld_s, done_s} !== {ev, ed}) begin
                fails++; $display("FAIL midrst_strobes k=%0d got %b exp %b", k, {ovld_s, done_s}, {ev, ed});
            end
            if (ovld_s) nwin++;
            if (done_s) ndone++;
            if (ev) begin
                tests++;
                if ({r1_s, r2_s, r3_s} !== {srow(r-2, c), srow(r-1, c), srow(r, c)}) begin
                    fails++; $display("FAIL midrst_win k=%0d got %h exp %h", k,
                        {r1_s, r2_s, r3_s}, {srow(r-2, c), srow(r-1, c), srow(r, c)});
                end
            end
        end
        tests++;
        if (nwin != 4 || ndone != 1) begin
            fails++; $display("FAIL midrst_counts got win=%0d done=%0d exp win=4 done=1", nwin, ndone);
        end
    endtask

    task automatic test_random_28();
        int k = 0, cyc = 0, nwin = 0, ndone = 0, bad = 0;
        int r, c;
        logic ev, ed;
        logic [7:0] pix;
        while (k < BW * BH && cyc < 20000) begin
            cyc++;
            if ($urandom_range(0, 3) == 0) begin
                step_b(1'b0, 8'($urandom));
                tests++;
                if ({ovld_b, done_b} !== 2'b00) begin
                    fails++; $display("FAIL rand_gap k=%0d got %b exp 00", k, {ovld_b, done_b});
                end
            end else begin
                r = k / BW; c = k % BW;
                pix = 8'($urandom);
                img_b[r][c] = pix;
                step_b(1'b1, pix);
                k++;
                ev = (r >= 2) && (c >= 2);
                ed = (r == BH - 1) && (c == BW - 1);
                tests++;
                if ({ovld_b, done_b} !== {ev, ed}) begin
                    fails++; $display("FAIL rand_strobes r=%0d c=%0d got %b exp %b", r, c, {ovld_b, done_b}, {ev, ed});
                end
                if (ovld_b && (r < 2 || c < 2)) bad++;
                if (ovld_b) nwin++;
                if (done_b) ndone++;
                if (ev) begin
                    tests++;
                    if ({r1_b, r2_b, r3_b} !== {brow(r-2, c), brow(r-1, c), brow(r, c)}) begin
                        fails++; $display("FAIL rand_win r=%0d c=%0d got %h exp %h", r, c,
                            {r1_b, r2_b, r3_b}, {brow(r-2, c), brow(r-1, c), brow(r, c)});
                    end
                end
            end
        end
        vld_b = 1'b0;
        tests++;
        if (k != BW * BH) begin
            fails++; $display("FAIL rand_budget got %0d pixels exp %0d", k, BW * BH);
        end
        tests++;
        if (nwin != (BW - 2) * (BH - 2)) begin
            fails++; $display("FAIL rand_count got %0d exp %0d", nwin, (BW - 2) * (BH - 2));
        end
        tests++;
        if (ndone != 1) begin
            fails++; $display("FAIL rand_done got %0d exp 1", ndone);
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL rand_border got %0d exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_frame_4x4();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        test_random_28();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

Streaming 3x3 window generator: accepts a raster-order pixel stream, one pixel per valid cycle, and emits every fully-inside 3x3 neighbourhood as three packed rows. It sits directly upstream of the 3x3 convolution kernel and drives that kernel's valid/window-row input bus. There is no padding, so each frame produces (IMG_W-2)*(IMG_H-2) windows. The bus has no backpressure.

## Interface
Parameters:
- WI, 8: pixel bit width. Pixel bits are raw data; the block does not interpret sign.
- IMG_W, 28: pixels per line. Must be 3 or more.
- IMG_H, 28: lines per frame. Must be 3 or more.

Ports:
- iClk  input  1  clock. All state updates on the rising edge.
- iRsn  input  1  reset. Asynchronous assertion, active-low.
- iInValid  input  1  iInData carries a pixel this cycle.
- iInData  input  WI  pixel, in raster order: left to right, then top to bottom.
- oOutValid  output  1  window outputs are valid this cycle. Registered.
- oWindowOutRow1  output  3*WI  top row of the window.
- oWindowOutRow2  output  3*WI  middle row of the window.
- oWindowOutRow3  output  3*WI  bottom row of the window.
- oFrameDone  output  1  one-cycle pulse, coincident with the last window of a frame.

Field order in every row: bits [3*WI-1 -: WI] hold the left column, [2*WI-1 -: WI] the centre column, [WI-1 -: WI] the right column.

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on accepted pixels (iInValid=1).
  - col wraps to 0 at IMG_W-1, and row then increments.
  - row wraps to 0 at IMG_H-1 when col wraps. The next pixel starts a new frame with no idle cycle required.
- Two line buffers, each IMG_W deep, hold the previous two lines.
  - On each accepted pixel, LB0 shifts in iInData and LB1 shifts in LB0's output.
  - The column taps therefore present pixel (row-1, col) and pixel (row-2, col).
- A 3x3 shift-register window shifts left one column on each accepted pixel.
  - New right column: {LB1 tap, LB0 tap, iInData}, going top to bottom.
- FSM, two states:
  - FILL: row < 2. Windows are never valid. Transition to RUN when the pixel at row=1, col=IMG_W-1 is accepted.
  - RUN: a window is valid for an accepted pixel when col >= 2. Transition to FILL on the frame's last pixel.
- For an accepted pixel at (r,c) with r>=2 and c>=2, the cycle after acceptance shows:
  - Row1 = {p(r-2,c-2), p(r-2,c-1), p(r-2,c)}
  - Row2 = {p(r-1,c-2), p(r-1,c-1), p(r-1,c)}
  - Row3 = {p(r,c-2), p(r,c-1), p(r,c)}
- Pixels at c<2 are suppressed so that a window never straddles two lines.
- Gaps (iInValid=0) freeze all state: counters, buffers, window and FSM.
  - oOutValid is 0 during a gap cycle.
  - Window data holds its last value.

## Timing
- Reset values:
  - oOutValid=0, oFrameDone=0, and all three window rows=0.
  - col=0, row=0, FSM=FILL.
  - Line-buffer contents are don't-care; FILL overwrites them before any of it is used.
- Latency: exactly 1 cycle from the accepting edge of the completing pixel to oOutValid=1.
- oOutValid is high for exactly one cycle per window.
  - Continuous input produces back-to-back valid windows within a line.
  - Each line has a 2-cycle gap at its start.
- oFrameDone=1 in the same cycle as the window for pixel (IMG_H-1, IMG_W-1). It is 0 at all other times.
- Reset mid-frame: outputs clear immediately. After release, the next accepted pixel is treated as (0,0) of a new frame.
- Frame boundary: line-buffer data from the old frame is never emitted. The FILL gating guarantees this.

## Structure
- Shared package cnn_pkg holds:
  - default constants WI, IMG_W, IMG_H;
  - the FSM state enum (FILL, RUN).
- Sub-module line_buffer (parameters WI and DEPTH=IMG_W) is instantiated twice.
  - It is an enable-gated shift delay: output = input delayed by DEPTH accepted pixels.
  - It may be implemented as a register chain or as a RAM with a circular pointer.
- Top level contains the counters, the FSM, the 3x3 window registers and the output registers.

## Test plan
- 4x4 frame with IMG_W=IMG_H=4, pixels 0x00..0x0F, continuous valid:
  - exactly 4 windows;
  - first window: Row1={00,01,02}, Row2={04,05,06}, Row3={08,09,0A};
  - last window: Row1={05,06,07}, Row2={09,0A,0B}, Row3={0D,0E,0F}, with oFrameDone=1.
- Same 4x4 frame with iInValid toggling 1,0,1,0:
  - identical window sequence;
  - oOutValid never high in a gap cycle;
  - each window 1 cycle after its completing pixel.
- Two back-to-back 4x4 frames (0x00..0x0F, then 0x10..0x1F):
  - 8 windows and 2 oFrameDone pulses;
  - first window of frame 2 is Row1={10,11,12}, Row2={14,15,16}, Row3={18,19,1A}, with no leakage from frame 1.
- Reset asserted after 9 pixels, then a full frame:
  - outputs read 0 during reset;
  - the following frame yields the normal 4 windows.
- Default 28x28 frame, random data:
  - 676 windows, checked against a software reference model;
  - exactly one oFrameDone;
  - oOutValid never high while row<2 or col<2.
